// File: rtl/pq_deq_if.sv
// Dequeue-side view of the priority queue as seen by the order checker:
// the controller's dequeue strobe plus the queue's status flags and head word.
interface pq_deq_if #(
    parameter int KW = 8,
    parameter int VW = 8
) ();
    logic              deq;
    logic              busy;
    logic              empty;
    logic [KW+VW-1:0]  kv_out;

    modport master (
        output deq,
        output busy,
        output empty,
        output kv_out
    );

    modport slave (
        input deq,
        input busy,
        input empty,
        input kv_out
    );
endinterface

// File: rtl/pq_deq_checker.sv
// Watches every accepted dequeue and flags keys leaving out of priority order
// or dequeues from an empty queue; raises a pass flag after TARGET clean ones.
module pq_deq_checker #(
    parameter int KW        = 8,
    parameter int VW        = 8,
    parameter int CNT_W     = 4,
    parameter int TARGET    = 15,
    parameter int MIN_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    pq_deq_if.slave          bus,
    output logic             error_comp,
    output logic             cteal_15,
    output logic [CNT_W-1:0] deq_count,
    output logic [1:0]       err_code,
    output logic [KW-1:0]    err_key,
    output logic [KW-1:0]    err_prev,
    output logic [CNT_W-1:0] err_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CHECK = 2'b01,
        ST_FAIL  = 2'b10,
        ST_PASS  = 2'b11
    } state_t;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_ORDER = 2'b01;
    localparam logic [1:0] CODE_UNDER = 2'b10;

    state_t            state_r;
    state_t            state_nx;
    logic [KW-1:0]     prev_r;
    logic [KW-1:0]     prev_nx;
    logic [CNT_W-1:0]  count_nx;
    logic [CNT_W-1:0]  count_inc_s;
    logic [1:0]        code_nx;
    logic [KW-1:0]     ekey_nx;
    logic [KW-1:0]     eprev_nx;
    logic [CNT_W-1:0]  eidx_nx;
    logic [KW-1:0]     key_s;
    logic              acc_s;
    logic              order_bad_s;
    logic              reach_s;

    // Decode the accepted-dequeue strobe and the ordering test on the head key.
    always_comb begin
        key_s       = bus.kv_out[KW+VW-1:VW];
        acc_s       = bus.deq & ~bus.busy & ((state_r == ST_IDLE) | (state_r == ST_CHECK));
        count_inc_s = deq_count + CNT_W'(1);
        reach_s     = (count_inc_s == CNT_W'(TARGET));
        if (MIN_FIRST != 0) begin
            order_bad_s = (key_s < prev_r);
        end else begin
            order_bad_s = (key_s > prev_r);
        end
    end

    // Next-state and next-register computation; terminal states hold everything.
    always_comb begin
        state_nx = state_r;
        prev_nx  = prev_r;
        count_nx = deq_count;
        code_nx  = err_code;
        ekey_nx  = err_key;
        eprev_nx = err_prev;
        eidx_nx  = err_idx;
        case (state_r)
            ST_IDLE: begin
                if (acc_s) begin
                    count_nx = count_inc_s;
                    if (bus.empty) begin
                        state_nx = ST_FAIL;
                        code_nx  = CODE_UNDER;
                        ekey_nx  = key_s;
                        eprev_nx = prev_r;
                        eidx_nx  = deq_count;
                    end else begin
                        prev_nx  = key_s;
                        state_nx = reach_s ? ST_PASS : ST_CHECK;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (acc_s) begin
                    count_nx = count_inc_s;
                    // Underflow outranks ordering when both apply.
                    if (bus.empty || order_bad_s) begin
                        state_nx = ST_FAIL;
                        code_nx  = bus.empty ? CODE_UNDER : CODE_ORDER;
                        ekey_nx  = key_s;
                        eprev_nx = prev_r;
                        eidx_nx  = deq_count;
                    end else begin
                        prev_nx  = key_s;
                        state_nx = reach_s ? ST_PASS : ST_CHECK;
                    end
                end else begin
                    state_nx = ST_CHECK;
                end
            end
            ST_FAIL: begin
                state_nx = ST_FAIL;
            end
            ST_PASS: begin
                state_nx = ST_PASS;
            end
            default: begin
                state_nx = ST_IDLE;
                code_nx  = CODE_NONE;
            end
        endcase
    end

    // State and output registers; rst and clr both return to a clean idle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_r    <= ST_IDLE;
            prev_r     <= {KW{1'b0}};
            deq_count  <= {CNT_W{1'b0}};
            err_code   <= CODE_NONE;
            err_key    <= {KW{1'b0}};
            err_prev   <= {KW{1'b0}};
            err_idx    <= {CNT_W{1'b0}};
            error_comp <= 1'b0;
            cteal_15   <= 1'b0;
        end else begin
            state_r    <= state_nx;
            prev_r     <= prev_nx;
            deq_count  <= count_nx;
            err_code   <= code_nx;
            err_key    <= ekey_nx;
            err_prev   <= eprev_nx;
            err_idx    <= eidx_nx;
            error_comp <= (state_nx == ST_FAIL);
            cteal_15   <= (state_nx == ST_PASS);
        end
    end

endmodule

// File: tb/tb_pq_deq_checker.sv
// Bench for pq_deq_checker: directed scenarios plus randomized dequeue traffic
// compared every cycle against a behavioural model of the ordering rules.
module tb_pq_deq_checker;

    localparam int TARGET = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;

    pq_deq_if #(.KW(8), .VW(8)) bus0 ();
    pq_deq_if #(.KW(8), .VW(8)) bus1 ();

    logic       o0_err, o0_pass, o1_err, o1_pass;
    logic [3:0] o0_cnt, o0_idx, o1_cnt, o1_idx;
    logic [1:0] o0_code, o1_code;
    logic [7:0] o0_key, o0_prev, o1_key, o1_prev;

    int total = 0;
    int bad   = 0;

    // Reference model state for the MIN_FIRST=1 instance
    logic       m_fail, m_pass, m_have;
    logic [7:0] m_prev, m_key, m_eprev;
    int         m_cnt, m_idx;
    logic [1:0] m_code;

    pq_deq_checker #(.KW(8), .VW(8), .CNT_W(4), .TARGET(TARGET), .MIN_FIRST(1)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus0),
        .error_comp(o0_err), .cteal_15(o0_pass), .deq_count(o0_cnt),
        .err_code(o0_code), .err_key(o0_key), .err_prev(o0_prev), .err_idx(o0_idx)
    );

    pq_deq_checker #(.KW(8), .VW(8), .CNT_W(4), .TARGET(TARGET), .MIN_FIRST(0)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus1),
        .error_comp(o1_err), .cteal_15(o1_pass), .deq_count(o1_cnt),
        .err_code(o1_code), .err_key(o1_key), .err_prev(o1_prev), .err_idx(o1_idx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic c, input logic d,
                                input logic b, input logic e, input logic [7:0] k);
        logic viol;
        if (r || c) begin
            m_fail = 1'b0; m_pass = 1'b0; m_have = 1'b0; m_prev = 8'd0;
            m_cnt = 0; m_idx = 0; m_code = 2'd0; m_key = 8'd0; m_eprev = 8'd0;
        end else if (!m_fail && !m_pass && d && !b) begin
            viol = e || (m_have && (k < m_prev));
            if (viol) begin
                m_fail  = 1'b1;
                m_code  = e ? 2'd2 : 2'd1;
                m_key   = k;
                m_eprev = m_prev;
                m_idx   = m_cnt;
            end else begin
                m_prev = k;
                m_have = 1'b1;
                if (m_cnt + 1 == TARGET) m_pass = 1'b1;
            end
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check_all(input string ph);
        check_eq({ph, " error_comp"}, 32'(o0_err), 32'(m_fail));
        check_eq({ph, " cteal_15"}, 32'(o0_pass), 32'(m_pass));
        check_eq({ph, " deq_count"}, 32'(o0_cnt), 32'(m_cnt));
        check_eq({ph, " err_code"}, 32'(o0_code), 32'(m_code));
        check_eq({ph, " err_key"}, 32'(o0_key), 32'(m_key));
        check_eq({ph, " err_prev"}, 32'(o0_prev), 32'(m_eprev));
        check_eq({ph, " err_idx"}, 32'(o0_idx), 32'(m_idx));
    endtask

    // One clock: drive dut0 inputs, advance the model at the edge, compare after it.
    task automatic step(input string ph, input logic r, input logic c, input logic d,
                        input logic b, input logic e, input logic [7:0] k);
        rst = r; clr = c;
        bus0.deq = d; bus0.busy = b; bus0.empty = e;
        bus0.kv_out = {k, 8'($urandom)};
        @(posedge clk);
        model_update(r, c, d, b, e, k);
        #1;
        check_all(ph);
    endtask

    task automatic acc(input string ph, input logic [7:0] k);
        step(ph, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, k);
    endtask

    task automatic idle(input string ph);
        step(ph, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic do_rst(input string ph);
        step(ph, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        logic [7:0] k;
        logic r, c, d, b, e;
        bus0.deq = 1'b0; bus0.busy = 1'b0; bus0.empty = 1'b0; bus0.kv_out = 16'd0;
        bus1.deq = 1'b0; bus1.busy = 1'b0; bus1.empty = 1'b0; bus1.kv_out = 16'd0;

        // Reset state and a clean ascending run
        do_rst("reset");
        check_eq("reset deq_count", 32'(o0_cnt), 32'd0);
        for (int i = 1; i <= 15; i++) acc("asc", 8'(i));
        check_eq("asc cteal_15", 32'(o0_pass), 32'd1);
        check_eq("asc deq_count", 32'(o0_cnt), 32'd15);
        check_eq("asc err_code", 32'(o0_code), 32'd0);
        acc("asc extra", 8'd0);
        check_eq("asc hold count", 32'(o0_cnt), 32'd15);

        // Order violation 3,5,4 then an ignored extra dequeue
        do_rst("rst2");
        acc("ord", 8'd3); acc("ord", 8'd5); acc("ord", 8'd4);
        check_eq("ord error_comp", 32'(o0_err), 32'd1);
        check_eq("ord err_code", 32'(o0_code), 32'd1);
        check_eq("ord err_key", 32'(o0_key), 32'd4);
        check_eq("ord err_prev", 32'(o0_prev), 32'd5);
        check_eq("ord err_idx", 32'(o0_idx), 32'd2);
        acc("ord extra", 8'd1);
        check_eq("ord hold count", 32'(o0_cnt), 32'd3);

        // Equal keys are legal
        do_rst("rst3");
        acc("eq", 8'd7); acc("eq", 8'd7); acc("eq", 8'd7);
        check_eq("eq error_comp", 32'(o0_err), 32'd0);
        check_eq("eq deq_count", 32'(o0_cnt), 32'd3);

        // Max-queue instance: 9,4,6 breaks non-increasing order
        do_rst("rst4");
        bus1.deq = 1'b1;
        bus1.kv_out = {8'd9, 8'd0}; idle("maxq");
        bus1.kv_out = {8'd4, 8'd0}; idle("maxq");
        bus1.kv_out = {8'd6, 8'd0}; idle("maxq");
        bus1.deq = 1'b0;
        check_eq("maxq error_comp", 32'(o1_err), 32'd1);
        check_eq("maxq err_code", 32'(o1_code), 32'd1);
        check_eq("maxq err_key", 32'(o1_key), 32'd6);
        check_eq("maxq err_prev", 32'(o1_prev), 32'd4);
        check_eq("maxq cteal_15", 32'(o1_pass), 32'd0);

        // Busy blocks acceptance; prev must become 2
        do_rst("rst5");
        for (int i = 0; i < 5; i++) step("busy", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom));
        check_eq("busy deq_count", 32'(o0_cnt), 32'd0);
        acc("busy", 8'd2);
        check_eq("busy accept count", 32'(o0_cnt), 32'd1);
        acc("busy", 8'd1);
        check_eq("busy prev", 32'(o0_prev), 32'd2);

        // Underflow after two accepts
        do_rst("rst6");
        acc("und", 8'd1); acc("und", 8'd2);
        step("und", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3);
        check_eq("und err_code", 32'(o0_code), 32'd2);
        check_eq("und err_idx", 32'(o0_idx), 32'd2);

        // Violation on the TARGET-th dequeue: fail wins
        do_rst("rst7");
        for (int i = 0; i < 14; i++) acc("last", 8'(10 + i));
        acc("last", 8'd5);
        check_eq("last error_comp", 32'(o0_err), 32'd1);
        check_eq("last cteal_15", 32'(o0_pass), 32'd0);
        check_eq("last err_idx", 32'(o0_idx), 32'd14);

        // clr recovers from FAIL, then pass with keys 0..14
        step("clr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("clr error_comp", 32'(o0_err), 32'd0);
        check_eq("clr err_code", 32'(o0_code), 32'd0);
        for (int i = 0; i < 15; i++) acc("zrun", 8'(i));
        check_eq("zrun cteal_15", 32'(o0_pass), 32'd1);

        // rst mid-run at count 7
        do_rst("rst8");
        for (int i = 0; i < 7; i++) acc("mid", 8'(i));
        check_eq("mid deq_count", 32'(o0_cnt), 32'd7);
        do_rst("mid rst");
        check_eq("mid rst count", 32'(o0_cnt), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(0, 99) < 2);
            c = ($urandom_range(0, 99) < 3) || ((m_fail || m_pass) && $urandom_range(0, 99) < 30);
            d = ($urandom_range(0, 99) < 70);
            b = ($urandom_range(0, 99) < 25);
            e = m_have && ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 9) == 0) k = 8'($urandom);
            else if (m_prev > 8'd250) k = m_prev;
            else k = m_prev + 8'($urandom_range(0, 3));
            step("rand", r, c, d, b, e, k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
